// File: rtl/mem_port_sequencer.sv
// -----------------------------------------------------------------------------
// mem_port_sequencer
//
// Arbitrates a single unified memory port between instruction fetch and the
// MEM-stage data access, and produces the stage advance enables that freeze
// or step the whole pipeline.
//
// A pipeline step is: IDLE (sample requests) -> D_ACC (if a load/store is
// wanted) -> I_ACC (if a fetch is wanted) -> ADV (one-cycle pulse on every
// stage enable) -> IDLE. The data access goes first because it belongs to the
// older instruction.
//
// Optional build macro: ACC_TIMEOUT_EN
//   defined   : an access with no mem_ack for WAIT_MAX cycles is abandoned,
//               acc_err is set (sticky) and the step carries on.
//   undefined : accesses wait for mem_ack forever; acc_err is tied 0.
//
// Ports
//   CLK, RST_n            clock (rising edge), async active-low reset
//   if_req/if_addr        fetch request and PC
//   if_rdata              last fetched instruction (registered)
//   dm_req/dm_we/dm_addr  load/store request, direction, address
//   dm_wdata/dm_wstrb     store data and byte enables
//   dm_rdata              last load data (registered)
//   mem_req..mem_wstrb    memory request side, mem_req held until mem_ack
//   mem_ack/mem_rdata     memory completion and read data
//   pipe_state[3:0]       stage advance enables (IF/ID, ID/EX, EX/MEM, MEM/WB)
//   acc_err               sticky access-timeout flag
// -----------------------------------------------------------------------------
module mem_port_sequencer #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [3:0]        dm_wstrb,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        pipe_state,
  output logic              acc_err
);

  if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_wait_max_range
    $error("mem_port_sequencer: WAIT_MAX must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2,
    ADV   = 2'd3
  } state_t;

  state_t state, state_nx;
  logic   pend_i;      // fetch still owed after the data access of this step
  logic   acc_abort;   // current access given up without an ack

`ifdef ACC_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       acc_err_q;

  // The last allowed wait cycle is the one where the counter reaches
  // WAIT_MAX-1; an ack in that same cycle still completes the access.
  assign acc_abort = (state == D_ACC || state == I_ACC) && !mem_ack &&
                     (wait_cnt == 8'(WAIT_MAX - 1));
  assign acc_err   = acc_err_q;
`else
  assign acc_abort = 1'b0;
  assign acc_err   = 1'b0;
`endif

  // Next state and memory-port outputs
  always_comb begin
    state_nx   = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = if_addr;
    mem_wdata  = dm_wdata;
    mem_wstrb  = 4'b0000;
    pipe_state = 4'b0000;
    case (state)
      IDLE: begin
        if (dm_req)      state_nx = D_ACC;
        else if (if_req) state_nx = I_ACC;
        else             state_nx = ADV;
      end
      D_ACC: begin
        mem_req   = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wstrb = dm_we ? dm_wstrb : 4'b0000;
        if (mem_ack || acc_abort) state_nx = pend_i ? I_ACC : ADV;
      end
      I_ACC: begin
        mem_req = 1'b1;
        if (mem_ack || acc_abort) state_nx = ADV;
      end
      ADV: begin
        pipe_state = 4'b1111;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and capture registers
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state    <= IDLE;
      pend_i   <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) pend_i <= if_req;
      if (state == D_ACC && mem_ack && !dm_we) dm_rdata <= mem_rdata;
      if (state == I_ACC && mem_ack) if_rdata <= mem_rdata;
    end
  end

`ifdef ACC_TIMEOUT_EN
  // Wait counter restarts on every state entry
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wait_cnt  <= 8'd0;
      acc_err_q <= 1'b0;
    end else begin
      if (state_nx != state) wait_cnt <= 8'd0;
      else if (state == D_ACC || state == I_ACC) wait_cnt <= wait_cnt + 8'd1;
      if (acc_abort) acc_err_q <= 1'b1;
    end
  end
`endif

endmodule
